mdu_ctrl: RTL and testbench

- Multiply/divide unit with its sequencer, sitting in the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E and models the multi-cycle latency with a busy counter.
- Owns the HI/LO registers.
- Produces the D-stage stall request for MD-class instructions, to be ORed with the Tuse/Tnew stall.

---
 rtl/mdu_ctrl_pkg.sv | 37 +++
 rtl/mdu_ctrl_if.sv | 25 ++
 rtl/mdu_ctrl.sv | 108 ++++++++++
 tb/tb_mdu_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared MD-unit definitions: op codes, default latencies, op-class decode helpers.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_t;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_res_t;

    function automatic logic md_is_start(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // D-stage decode: any op that touches HI/LO must wait for the unit to go idle.
    function automatic logic md_is_class(input md_op_t op);
        return op != MD_NONE;
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage MD request/response bundle plus the D-stage stall hook.
interface mdu_ctrl_if;
    import mdu_ctrl_pkg::*;

    md_op_t      E_MDOp;
    logic [31:0] E_rs;
    logic [31:0] E_rt;
    logic        D_is_md;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] E_MDout;
    logic        D_md_stall;

    modport master (
        output E_MDOp, E_rs, E_rt, D_is_md,
        input  busy, HI, LO, E_MDout, D_md_stall
    );

    modport slave (
        input  E_MDOp, E_rs, E_rt, D_is_md,
        output busy, HI, LO, E_MDout, D_md_stall
    );

endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit with HI/LO and a busy counter modelling multi-cycle latency.
// Latency: result lands in HI/LO MULT_CYCLES/DIV_CYCLES edges after the start edge.
// Backpressure: D_md_stall holds MD-class ops in D during the start cycle and while busy.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_we;

    logic             start;
    logic             busy_c;
    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic             div_ovf;
    logic [31:0]      divisor;
    logic [31:0]      quo_s;
    logic [31:0]      rem_s;
    logic [31:0]      quo_u;
    logic [31:0]      rem_u;
    md_res_t          res;
    logic             res_we;

    assign start  = md_is_start(md.E_MDOp);
    assign busy_c = (cnt != '0);

    assign prod_s = $signed({{32{md.E_rs[31]}}, md.E_rs}) * $signed({{32{md.E_rt[31]}}, md.E_rt});
    assign prod_u = {32'd0, md.E_rs} * {32'd0, md.E_rt};

    // Dividing by 1 yields the wrapped two's-complement answer for INT_MIN/-1
    // and keeps the divider defined when rt is zero (that result is never committed).
    assign div_ovf = (md.E_rs == 32'h8000_0000) && (md.E_rt == 32'hFFFF_FFFF);
    assign divisor = ((md.E_rt == 32'd0) || div_ovf) ? 32'd1 : md.E_rt;
    assign quo_s   = $signed(md.E_rs) / $signed(divisor);
    assign rem_s   = $signed(md.E_rs) % $signed(divisor);
    assign quo_u   = md.E_rs / divisor;
    assign rem_u   = md.E_rs % divisor;

    always_comb begin
        res    = '0;
        res_we = 1'b1;
        case (md.E_MDOp)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV:   res = '{hi: rem_s, lo: quo_s};
            MD_DIVU:  res = '{hi: rem_u, lo: quo_u};
            default:  res = '0;
        endcase
        if (md_is_div(md.E_MDOp) && (md.E_rt == 32'd0)) begin
            res_we = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_we <= 1'b0;
        end else if (busy_c) begin
            // Starts and moves to HI/LO are dropped while an operation is in flight.
            cnt <= cnt - 1'b1;
            if ((cnt == CNT_W'(1)) && pend_we) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end
        end else if (start) begin
            pend_hi <= res.hi;
            pend_lo <= res.lo;
            pend_we <= res_we;
            cnt     <= md_is_div(md.E_MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md.E_MDOp == MD_MTHI) begin
            hi_q <= md.E_rs;
        end else if (md.E_MDOp == MD_MTLO) begin
            lo_q <= md.E_rs;
        end
    end

    always_comb begin
        case (md.E_MDOp)
            MD_MFHI: md.E_MDout = hi_q;
            MD_MFLO: md.E_MDout = lo_q;
            default: md.E_MDout = 32'd0;
        endcase
    end

    assign md.busy       = busy_c;
    assign md.HI         = hi_q;
    assign md.LO         = lo_q;
    assign md.D_md_stall = md.D_is_md & (start | busy_c);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO queued at start, compared at commit.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    md_res_t exp_q[$];

    mdu_ctrl_if md_if();

    mdu_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Issue one start, scramble operands afterwards, count busy cycles, compare the commit.
    task automatic run_md(input md_op_t op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] ehi, input logic [31:0] elo, input int n,
                          input string name);
        int cycles;
        md_res_t e;
        exp_q.push_back('{hi: ehi, lo: elo});
        md_if.E_MDOp = op;
        md_if.E_rs   = rs;
        md_if.E_rt   = rt;
        tick();
        md_if.E_MDOp = MD_NONE;
        md_if.E_rs   = $urandom;
        md_if.E_rt   = $urandom;
        cycles = 0;
        while (md_if.busy && cycles < 100) begin
            cycles++;
            tick();
        end
        checks++;
        if (cycles !== n) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d expected %0d", name, cycles, n);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard: queue empty, expected 1 entry", name);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_hi"}, md_if.HI, e.hi);
            chk({name, "_lo"}, md_if.LO, e.lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        md_if.E_MDOp  = MD_NONE;
        md_if.E_rs    = '0;
        md_if.E_rt    = '0;
        md_if.D_is_md = 1'b1;
        #1;
        chk("reset_busy", {31'd0, md_if.busy}, 32'd0);
        chk("reset_hi", md_if.HI, 32'd0);
        chk("reset_lo", md_if.LO, 32'd0);
        chk("reset_mdout", md_if.E_MDout, 32'd0);
        chk("reset_stall", {31'd0, md_if.D_md_stall}, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        md_if.D_is_md = 1'b0;
        tick();
    endtask

    task automatic test_mult();
        run_md(MD_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, "mult_neg");
        run_md(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5, "multu");
    endtask

    task automatic test_div();
        run_md(MD_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_neg");
        run_md(MD_DIVU, 32'd7,         32'd2,        32'd1,         32'd3,         10, "divu");
        run_md(MD_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 10, "div_negdivisor");
    endtask

    task automatic test_stall();
        int stall_cycles;
        md_if.D_is_md = 1'b1;
        md_if.E_MDOp  = MD_MULT;
        md_if.E_rs    = 32'h10;
        md_if.E_rt    = 32'h20;
        #1;
        chk("stall_start_cycle", {31'd0, md_if.D_md_stall}, 32'd1);
        stall_cycles = 1;
        tick();
        md_if.E_MDOp = MD_NONE;
        while (md_if.D_md_stall && stall_cycles < 100) begin
            stall_cycles++;
            tick();
        end
        chk("stall_total", stall_cycles, 32'd6);
        md_if.E_MDOp = MD_MFLO;
        #1;
        chk("stall_mflo_new", md_if.E_MDout, 32'h200);
        md_if.D_is_md = 1'b0;
        md_if.E_MDOp  = MD_NONE;
        tick();
    endtask

    task automatic test_mtx();
        int cycles;
        md_res_t e;
        md_if.E_MDOp = MD_MTHI;
        md_if.E_rs   = 32'h1234;
        tick();
        md_if.E_MDOp = MD_NONE;
        chk("mthi_hi", md_if.HI, 32'h1234);
        md_if.E_MDOp = MD_MFHI;
        #1;
        chk("mfhi_out", md_if.E_MDout, 32'h1234);
        md_if.E_MDOp = MD_MTLO;
        md_if.E_rs   = 32'h55;
        tick();
        md_if.E_MDOp = MD_MFLO;
        #1;
        chk("mflo_out", md_if.E_MDout, 32'h55);
        md_if.E_MDOp = MD_NONE;
        #1;
        chk("none_out", md_if.E_MDout, 32'd0);

        // mtlo and a second start while busy must both be dropped
        exp_q.push_back('{hi: 32'd0, lo: 32'd35});
        md_if.E_MDOp = MD_MULT;
        md_if.E_rs   = 32'd5;
        md_if.E_rt   = 32'd7;
        tick();
        md_if.E_MDOp = MD_MTLO;
        md_if.E_rs   = 32'hDEAD;
        tick();
        chk("mtlo_busy_lo", md_if.LO, 32'h55);
        md_if.E_MDOp = MD_DIV;
        md_if.E_rs   = 32'd100;
        md_if.E_rt   = 32'd3;
        tick();
        md_if.E_MDOp = MD_NONE;
        cycles = 0;
        while (md_if.busy && cycles < 100) begin
            cycles++;
            tick();
        end
        chk("start_busy_remaining", cycles, 32'd3);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL busy_ignore_scoreboard: queue empty, expected 1 entry");
        end else begin
            e = exp_q.pop_front();
            chk("busy_ignore_hi", md_if.HI, e.hi);
            chk("busy_ignore_lo", md_if.LO, e.lo);
        end
    endtask

    task automatic test_div0();
        md_if.E_MDOp = MD_MTHI;
        md_if.E_rs   = 32'd5;
        tick();
        md_if.E_MDOp = MD_MTLO;
        md_if.E_rs   = 32'd6;
        tick();
        run_md(MD_DIV, 32'h20, 32'd0, 32'd5, 32'd6, 10, "div_by_zero");
    endtask

    task automatic test_reset_mid();
        md_if.E_MDOp = MD_DIV;
        md_if.E_rs   = 32'd100;
        md_if.E_rt   = 32'd7;
        tick();
        md_if.E_MDOp = MD_NONE;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_busy", {31'd0, md_if.busy}, 32'd0);
        chk("midreset_hi", md_if.HI, 32'd0);
        chk("midreset_lo", md_if.LO, 32'd0);
        tick();
        reset = 1'b0;
        repeat (12) tick();
        chk("postreset_hi", md_if.HI, 32'd0);
        chk("postreset_lo", md_if.LO, 32'd0);
        chk("postreset_busy", {31'd0, md_if.busy}, 32'd0);
        run_md(MD_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 5, "mult_after_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_mtx();
        test_div0();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
